// File: rtl/pipe_buf_pkg.sv
// Shared definitions for the elastic pipeline buffer stage.
// State encoding doubles as the occupancy count.
package pipe_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pb_state_e;

    localparam int PB_NO_HALT = -1;

endpackage

// File: rtl/pipe_buf_ctrl.sv
// Handshake control for pipe_buf_stage: occupancy FSM, halt lock, ready
// generation and load enables for the main (M) and skid (S) registers.
module pipe_buf_ctrl
    import pipe_buf_pkg::*;
#(
    parameter bit SKID = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       in_halt,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic       halted,
    output logic [1:0] occupancy,
    output logic       load_m,
    output logic       m_from_s,
    output logic       load_s
);

    pb_state_e state;
    pb_state_e state_nxt;
    logic      halt_lock;
    logic      push;
    logic      pop;

    // SKID=0 trades a combinational out_ready->in_ready path for a single register.
    generate
        if (SKID) begin : g_skid_ready
            assign in_ready = (state != TWO) && !halt_lock && !flush;
        end else begin : g_plain_ready
            assign in_ready = ((state == EMPTY) || out_ready) && !halt_lock && !flush;
        end
    endgenerate

    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign halted    = halt_lock && (state == EMPTY);
    assign occupancy = state;

    always_comb begin
        state_nxt = state;
        load_m    = 1'b0;
        load_s    = 1'b0;
        m_from_s  = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt = ONE;
                        load_m    = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        load_m = 1'b1;
                    end else if (push) begin
                        state_nxt = TWO;
                        load_s    = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_nxt = ONE;
                        load_m    = 1'b1;
                        m_from_s  = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            halt_lock <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                halt_lock <= 1'b0;
            end else if (push && in_halt) begin
                halt_lock <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_buf_stage.sv
// Elastic valid/ready pipeline register with optional 2-entry skid,
// synchronous flush and halt-marker capture. Payload is opaque.
module pipe_buf_stage
    import pipe_buf_pkg::*;
#(
    parameter int              DATA_W   = 64,
    parameter bit              SKID     = 1'b1,
    parameter int              HALT_BIT = 0,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              halted,
    output logic [1:0]        occupancy
);

    logic [DATA_W-1:0] m_reg;
    logic [DATA_W-1:0] s_reg;
    logic              in_halt;
    logic              load_m;
    logic              m_from_s;
    logic              load_s;

    generate
        if (HALT_BIT >= 0) begin : g_halt
            assign in_halt = in_data[HALT_BIT];
        end else begin : g_no_halt
            assign in_halt = 1'b0;
        end
    endgenerate

    pipe_buf_ctrl #(
        .SKID(SKID)
    ) u_ctrl (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_halt   (in_halt),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .halted    (halted),
        .occupancy (occupancy),
        .load_m    (load_m),
        .m_from_s  (m_from_s),
        .load_s    (load_s)
    );

    // With SKID=0 load_s never asserts, so S is constant and trims away.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reg <= '0;
            s_reg <= '0;
        end else begin
            if (load_m) begin
                m_reg <= m_from_s ? s_reg : in_data;
            end
            if (load_s) begin
                s_reg <= in_data;
            end
        end
    end

    assign out_data = out_valid ? m_reg : BUBBLE;

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Directed testbench for pipe_buf_stage: skid, plain and halt-capturing
// instances share one stimulus bus; each task checks the instance it targets.
module tb_pipe_buf_stage;
    import pipe_buf_pkg::*;

    localparam logic [7:0] BUB = 8'hEE;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b0;

    logic       k_in_ready, k_out_valid, k_halted;
    logic [7:0] k_out_data;
    logic [1:0] k_occ;
    logic       p_in_ready, p_out_valid, p_halted;
    logic [7:0] p_out_data;
    logic [1:0] p_occ;
    logic       h_in_ready, h_out_valid, h_halted;
    logic [7:0] h_out_data;
    logic [1:0] h_occ;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_buf_stage #(.DATA_W(8), .SKID(1'b1), .HALT_BIT(PB_NO_HALT), .BUBBLE(BUB)) dut_skid (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(k_in_ready),
        .in_data(in_data), .out_valid(k_out_valid), .out_ready(out_ready), .out_data(k_out_data),
        .halted(k_halted), .occupancy(k_occ));

    pipe_buf_stage #(.DATA_W(8), .SKID(1'b0), .HALT_BIT(PB_NO_HALT), .BUBBLE(BUB)) dut_plain (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(p_in_ready),
        .in_data(in_data), .out_valid(p_out_valid), .out_ready(out_ready), .out_data(p_out_data),
        .halted(p_halted), .occupancy(p_occ));

    pipe_buf_stage #(.DATA_W(8), .SKID(1'b1), .HALT_BIT(0), .BUBBLE(BUB)) dut_halt (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(h_in_ready),
        .in_data(in_data), .out_valid(h_out_valid), .out_ready(out_ready), .out_data(h_out_data),
        .halted(h_halted), .occupancy(h_occ));

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        reset_n   = 1'b0;
        #2;
        reset_n   = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #7;
        n_cmp++; if (k_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got=%b want=0", k_out_valid); end
        n_cmp++; if (k_out_data !== BUB) begin n_fail++; $display("[TB] FAIL reset_out_data got=%h want=%h", k_out_data, BUB); end
        n_cmp++; if (k_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got=%b want=1", k_in_ready); end
        n_cmp++; if (k_occ !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_occupancy got=%0d want=0", k_occ); end
        n_cmp++; if (h_halted !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_halted got=%b want=0", h_halted); end
        flush = 1'b1;
        #1;
        n_cmp++; if (k_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_in_ready got=%b want=0", k_in_ready); end
        flush = 1'b0;
        do_reset();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            #1;
            n_cmp++; if (k_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_in_ready[%0d] got=%b want=1", i, k_in_ready); end
            tick();
            n_cmp++; if (k_out_valid !== 1'b1 || k_out_data !== 8'(i)) begin n_fail++; $display("[TB] FAIL b2b_out[%0d] got=%b/%h want=1/%h", i, k_out_valid, k_out_data, 8'(i)); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (k_out_valid !== 1'b0 || k_out_data !== BUB) begin n_fail++; $display("[TB] FAIL b2b_drain got=%b/%h want=0/%h", k_out_valid, k_out_data, BUB); end
    endtask

    task automatic test_skid_stall();
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'h0A;
        tick();
        in_data  = 8'h0B;
        #1;
        n_cmp++; if (k_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_ready_one got=%b want=1", k_in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (k_occ !== 2'd2 || k_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_full got=occ%0d/rdy%b want=occ2/rdy0", k_occ, k_in_ready); end
        n_cmp++; if (k_out_data !== 8'h0A) begin n_fail++; $display("[TB] FAIL stall_hold got=%h want=0a", k_out_data); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (k_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_ready_registered got=%b want=0", k_in_ready); end
        tick();
        n_cmp++; if (k_out_data !== 8'h0B || k_occ !== 2'd1) begin n_fail++; $display("[TB] FAIL stall_second got=%h/occ%0d want=0b/occ1", k_out_data, k_occ); end
        tick();
        n_cmp++; if (k_out_data !== BUB || k_occ !== 2'd0) begin n_fail++; $display("[TB] FAIL stall_empty got=%h/occ%0d want=%h/occ0", k_out_data, k_occ, BUB); end
    endtask

    task automatic test_flush_pop();
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'h0A;
        tick();
        in_data  = 8'h0B;
        tick();
        in_valid  = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (k_out_valid !== 1'b1 || k_out_data !== 8'h0A) begin n_fail++; $display("[TB] FAIL flush_deliver got=%b/%h want=1/0a", k_out_valid, k_out_data); end
        tick();
        flush = 1'b0;
        n_cmp++; if (k_occ !== 2'd0 || k_out_valid !== 1'b0 || k_out_data !== BUB) begin n_fail++; $display("[TB] FAIL flush_empty got=occ%0d/%b/%h want=occ0/0/%h", k_occ, k_out_valid, k_out_data, BUB); end
    endtask

    task automatic test_plain_toggle();
        logic [7:0] next_val;
        logic [7:0] exp_head;
        do_reset();
        next_val = 8'h11;
        exp_head = 8'h00;
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_data   = next_val;
            out_ready = (c % 2 == 0);
            #1;
            n_cmp++; if (p_in_ready !== out_ready) begin n_fail++; $display("[TB] FAIL plain_ready[%0d] got=%b want=%b", c, p_in_ready, out_ready); end
            if (c > 0) begin
                n_cmp++; if (p_out_valid !== 1'b1 || p_out_data !== exp_head) begin n_fail++; $display("[TB] FAIL plain_head[%0d] got=%b/%h want=1/%h", c, p_out_valid, p_out_data, exp_head); end
            end
            if (out_ready) begin
                exp_head = next_val;
                next_val = next_val + 8'd1;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (p_out_data !== 8'h14) begin n_fail++; $display("[TB] FAIL plain_last got=%h want=14", p_out_data); end
        tick();
        n_cmp++; if (p_out_valid !== 1'b0 || p_occ !== 2'd0) begin n_fail++; $display("[TB] FAIL plain_drain got=%b/occ%0d want=0/occ0", p_out_valid, p_occ); end
    endtask

    task automatic test_halt();
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'h03;
        #1;
        n_cmp++; if (h_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_accept got=%b want=1", h_in_ready); end
        tick();
        in_data = 8'h04;
        #1;
        n_cmp++; if (h_in_ready !== 1'b0 || h_occ !== 2'd1 || h_halted !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_lock got=rdy%b/occ%0d/h%b want=rdy0/occ1/h0", h_in_ready, h_occ, h_halted); end
        tick();
        n_cmp++; if (h_occ !== 2'd1 || h_out_data !== 8'h03) begin n_fail++; $display("[TB] FAIL halt_blocked got=occ%0d/%h want=occ1/03", h_occ, h_out_data); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (h_out_valid !== 1'b0 || h_halted !== 1'b1 || h_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_drained got=v%b/h%b/rdy%b want=v0/h1/rdy0", h_out_valid, h_halted, h_in_ready); end
        tick();
        n_cmp++; if (h_occ !== 2'd0) begin n_fail++; $display("[TB] FAIL halt_no_intake got=occ%0d want=occ0", h_occ); end
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        n_cmp++; if (h_halted !== 1'b0 || h_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_flush got=h%b/rdy%b want=h0/rdy1", h_halted, h_in_ready); end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'h0A;
        tick();
        in_data  = 8'h0B;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (k_occ !== 2'd2) begin n_fail++; $display("[TB] FAIL areset_fill got=occ%0d want=occ2", k_occ); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (k_occ !== 2'd0 || k_out_valid !== 1'b0 || k_out_data !== BUB || k_in_ready !== 1'b1 || k_halted !== 1'b0) begin
            n_fail++; $display("[TB] FAIL areset_clear got=occ%0d/v%b/%h/rdy%b/h%b want=occ0/v0/%h/rdy1/h0", k_occ, k_out_valid, k_out_data, k_in_ready, k_halted, BUB);
        end
        reset_n = 1'b1;
        tick();
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (k_out_valid !== 1'b1 || k_out_data !== 8'h5A) begin n_fail++; $display("[TB] FAIL areset_first_push got=%b/%h want=1/5a", k_out_valid, k_out_data); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_skid_stall();
        test_flush_pop();
        test_plain_toggle();
        test_halt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
